// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, instruction field slices
// and the fetch FSM state encoding.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam int OPCODE_MSB = 7;
    localparam int OPCODE_LSB = 3;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } fetch_state_t;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [DATA_W_DEF-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head entry is presented combinationally
// and reads as zero while empty.
module fetch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_push = i_push & ~i_flush & ~o_full;
    assign w_do_pop  = i_pop & ~i_flush & ~o_empty;
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: the storage array has no reset; a flush or reset only clears pointers
    // and count, so stale entries are never observable and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues one byte read at a time, buffers
// {pc, byte} pairs in a prefetch FIFO and hands them to decode in order.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int                CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] ONE_SHORT = CNT_W'(DEPTH - 1);

    fetch_state_t        r_state;
    logic [ADDR_W-1:0]   r_fetch_pc;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic [CNT_W-1:0]          w_count;
    logic [ADDR_W+DATA_W-1:0]  w_head;

    // Request and address come only from registers: no input-to-output path.
    assign mem_req    = (r_state == ST_FETCH);
    assign mem_addr   = r_fetch_pc;

    assign w_push     = mem_req & mem_ack & ~redirect & ~w_full;
    assign w_pop      = inst_valid & inst_ready & ~redirect;
    assign inst_valid = ~w_empty;
    assign {inst_pc, inst} = w_head;

    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_wdata ({r_fetch_pc, mem_rdata}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_BOOT;
            r_fetch_pc <= RESET_PC;
        end else if (redirect) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= redirect_addr;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 1'b1;
            end
            case (r_state)
                ST_BOOT:  r_state <= ST_FETCH;
                // Stop requesting the moment the last free slot is filled.
                ST_FETCH: if (w_push && !w_pop && w_count == ONE_SHORT) r_state <= ST_FULL;
                ST_FULL:  if (w_pop) r_state <= ST_FETCH;
                default:  r_state <= ST_BOOT;
            endcase
        end
    end

endmodule
